// File: rtl/checkpoint_keeper.sv
// Checkpoint owner: latches the player position on a save pulse and runs the
// death -> load -> invincibility-blink respawn sequence, one step per frame.
module checkpoint_keeper #(
  parameter logic [9:0] INIT_X       = 10'd32,
  parameter logic [9:0] INIT_Y       = 10'd400,
  parameter int         DEATH_FRAMES = 30,
  parameter int         BLINK_FRAMES = 60,
  parameter int         BLINK_PERIOD = 4
) (
  input  logic       frame_clk,
  input  logic       Reset_h,
  input  logic       saved,
  input  logic [9:0] Player_X,
  input  logic [9:0] Player_Y,
  input  logic       Player_dead,
  output logic [9:0] Respawn_X,
  output logic [9:0] Respawn_Y,
  output logic       load_pos,
  output logic       freeze,
  output logic       invincible,
  output logic       blink,
  output logic [3:0] Save_count,
  output logic       busy
);

  // BLINK_PERIOD is a power of two, so cnt/BLINK_PERIOD being odd is one bit.
  localparam int         BLINK_BIT  = $clog2(BLINK_PERIOD);
  localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, DYING, LOAD, BLINK} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       save_acc;
  logic [9:0] ck_x, ck_y;
  logic [3:0] save_cnt;

  always_ff @(posedge frame_clk) begin
    if (Reset_h) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      ck_x     <= INIT_X;
      ck_y     <= INIT_Y;
      save_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (save_acc) begin
        ck_x <= Player_X;
        ck_y <= Player_Y;
        if (save_cnt != 4'hf)
          save_cnt <= save_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    save_acc   = 1'b0;
    freeze     = 1'b0;
    load_pos   = 1'b0;
    invincible = 1'b0;
    blink      = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // Death takes priority; a coincident save is dropped.
        if (Player_dead) begin
          state_nxt = DYING;
          cnt_nxt   = 8'd0;
        end else if (saved) begin
          save_acc = 1'b1;
        end
      end
      DYING: begin
        freeze  = 1'b1;
        cnt_nxt = cnt + 8'd1;
        if (cnt == DEATH_LAST)
          state_nxt = LOAD;
      end
      LOAD: begin
        freeze     = 1'b1;
        load_pos   = 1'b1;
        invincible = 1'b1;
        state_nxt  = BLINK;
        cnt_nxt    = 8'd0;
      end
      BLINK: begin
        invincible = 1'b1;
        blink      = cnt[BLINK_BIT];
        cnt_nxt    = cnt + 8'd1;
        if (cnt == BLINK_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 8'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  assign Respawn_X  = ck_x;
  assign Respawn_Y  = ck_y;
  assign Save_count = save_cnt;

endmodule

// File: tb/tb_checkpoint_keeper.sv
// Directed bench for checkpoint_keeper with default parameters.
module tb_checkpoint_keeper;

  logic       frame_clk = 1'b0;
  logic       Reset_h = 1'b0;
  logic       saved = 1'b0;
  logic [9:0] Player_X = 10'd0;
  logic [9:0] Player_Y = 10'd0;
  logic       Player_dead = 1'b0;
  logic [9:0] Respawn_X, Respawn_Y;
  logic       load_pos, freeze, invincible, blink, busy;
  logic [3:0] Save_count;

  int checks = 0;
  int errors = 0;

  checkpoint_keeper dut (
    .frame_clk  (frame_clk),
    .Reset_h    (Reset_h),
    .saved      (saved),
    .Player_X   (Player_X),
    .Player_Y   (Player_Y),
    .Player_dead(Player_dead),
    .Respawn_X  (Respawn_X),
    .Respawn_Y  (Respawn_Y),
    .load_pos   (load_pos),
    .freeze     (freeze),
    .invincible (invincible),
    .blink      (blink),
    .Save_count (Save_count),
    .busy       (busy)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset_h = 1'b1;
    step();
    Reset_h = 1'b0;
  endtask

  // Full death sequence from IDLE; c counts cycles after the edge sampling Player_dead.
  task automatic death_seq(input logic [9:0] ex, input logic [9:0] ey);
    Player_dead = 1'b1;
    step();
    Player_dead = 1'b0;
    for (int c = 1; c <= 92; c++) begin
      chk($sformatf("freeze c=%0d", c), 32'(freeze), 32'(c <= 31));
      chk($sformatf("load_pos c=%0d", c), 32'(load_pos), 32'(c == 31));
      chk($sformatf("invincible c=%0d", c), 32'(invincible), 32'(c >= 31 && c <= 91));
      chk($sformatf("busy c=%0d", c), 32'(busy), 32'(c <= 91));
      chk($sformatf("blink c=%0d", c), 32'(blink),
          (c >= 32 && c <= 91) ? 32'(((c - 32) / 4) % 2) : 32'd0);
      if (c == 31) begin
        chk("load X", 32'(Respawn_X), 32'(ex));
        chk("load Y", 32'(Respawn_Y), 32'(ey));
      end
      step();
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst X", 32'(Respawn_X), 32'd32);
    chk("rst Y", 32'(Respawn_Y), 32'd400);
    chk("rst count", 32'(Save_count), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst freeze", 32'(freeze), 32'd0);
    chk("rst load_pos", 32'(load_pos), 32'd0);
    chk("rst invincible", 32'(invincible), 32'd0);
    chk("rst blink", 32'(blink), 32'd0);

    // Death with reset checkpoint
    death_seq(10'd32, 10'd400);

    // Save then death loads the saved position
    Player_X = 10'd200; Player_Y = 10'd150; saved = 1'b1;
    step();
    saved = 1'b0;
    chk("save X", 32'(Respawn_X), 32'd200);
    chk("save Y", 32'(Respawn_Y), 32'd150);
    chk("save count", 32'(Save_count), 32'd1);
    chk("save busy", 32'(busy), 32'd0);
    death_seq(10'd200, 10'd150);

    // Save and death together: death wins
    do_reset();
    Player_X = 10'd300; Player_Y = 10'd100; saved = 1'b1; Player_dead = 1'b1;
    step();
    saved = 1'b0; Player_dead = 1'b0;
    chk("tie busy", 32'(busy), 32'd1);
    chk("tie freeze", 32'(freeze), 32'd1);
    chk("tie X", 32'(Respawn_X), 32'd32);
    chk("tie Y", 32'(Respawn_Y), 32'd400);
    chk("tie count", 32'(Save_count), 32'd0);

    // Save during DYING is ignored
    Player_X = 10'd10; Player_Y = 10'd10; saved = 1'b1;
    step();
    saved = 1'b0;
    chk("dying save X", 32'(Respawn_X), 32'd32);
    chk("dying save Y", 32'(Respawn_Y), 32'd400);
    chk("dying save count", 32'(Save_count), 32'd0);
    chk("dying freeze", 32'(freeze), 32'd1);
    for (int i = 0; i < 200 && busy; i++) step();
    chk("return idle", 32'(busy), 32'd0);

    // 16 saves saturate the counter, positions still latched
    for (int i = 0; i < 16; i++) begin
      Player_X = 10'(i * 10 + 5); Player_Y = 10'(i * 20 + 7); saved = 1'b1;
      step();
      saved = 1'b0;
      chk($sformatf("sat count %0d", i), 32'(Save_count), (i < 15) ? 32'(i + 1) : 32'd15);
      chk($sformatf("sat X %0d", i), 32'(Respawn_X), 32'(i * 10 + 5));
      chk($sformatf("sat Y %0d", i), 32'(Respawn_Y), 32'(i * 20 + 7));
    end

    // Reset mid-DYING aborts the sequence without a load strobe
    Player_dead = 1'b1;
    step();
    Player_dead = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("pre-abort freeze", 32'(freeze), 32'd1);
    chk("pre-abort count", 32'(Save_count), 32'd15);
    do_reset();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort freeze", 32'(freeze), 32'd0);
    chk("abort count", 32'(Save_count), 32'd0);
    chk("abort X", 32'(Respawn_X), 32'd32);
    chk("abort Y", 32'(Respawn_Y), 32'd400);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("abort no load %0d", i), 32'(load_pos), 32'd0);
      chk($sformatf("abort idle %0d", i), 32'(busy), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/checkpoint_keeper.md
# checkpoint_keeper

Consumes the one-frame `saved` pulse from the save-point sprite and owns the player's checkpoint. On a save it latches the player position; on player death it runs the respawn sequence (death freeze, position load, invincibility blink) and hands the stored checkpoint back to the player/motion logic. It sits between the save-point sprites and the player module, and is clocked once per frame on `frame_clk`.

## Interface

Parameters:

- `INIT_X`, default 10'd32: checkpoint X after reset.
- `INIT_Y`, default 10'd400: checkpoint Y after reset.
- `DEATH_FRAMES`, default 30: frames spent in DYING (1..255).
- `BLINK_FRAMES`, default 60: frames spent in BLINK (1..255).
- `BLINK_PERIOD`, default 4: frames per blink half-period (power of two, 1..64).

Ports:

- `frame_clk` in 1: the single clock. Everything advances one step per frame.
- `Reset_h` in 1: synchronous, active-high reset.
- `saved` in 1: one-cycle save pulse from the save-point block (OR of all save points).
- `Player_X`, `Player_Y` in 10 each: current player top-left position.
- `Player_dead` in 1: level signal, high while the player is dead.
- `Respawn_X`, `Respawn_Y` out 10 each: stored checkpoint, always driven.
- `load_pos` out 1: one-cycle strobe; the player module copies `Respawn_X/Y` and clears its dead flag.
- `freeze` out 1: player control disabled.
- `invincible` out 1: player ignores damage.
- `blink` out 1: sprite-hide toggle for the renderer (1 = hide).
- `Save_count` out 4: number of accepted saves, saturating at 15.
- `busy` out 1: high in any state other than IDLE.

## Operation

- States: IDLE, DYING, LOAD, BLINK. There is one 8-bit frame counter `cnt`.
- Outputs are Moore-decoded from the registered state and `cnt`:
  - `freeze` = 1 in DYING or LOAD.
  - `load_pos` = 1 in LOAD only.
  - `invincible` = 1 in LOAD or BLINK.
  - `busy` = state != IDLE.
  - `blink` = 1 in BLINK when `(cnt / BLINK_PERIOD)` is odd; 0 everywhere else.
- IDLE:
  - `Player_dead`=1 moves to DYING with `cnt`<=0.
  - Otherwise, `saved`=1 latches `Player_X/Y` into the checkpoint registers and increments `Save_count` (saturating at 15).
  - If `saved` and `Player_dead` are both high in the same cycle, death wins: the save is discarded and the count is unchanged.
- DYING: `cnt` increments each frame. When `cnt`==DEATH_FRAMES-1, move to LOAD.
- LOAD: lasts exactly one cycle, then moves to BLINK with `cnt`<=0.
- BLINK: `cnt` increments each frame. When `cnt`==BLINK_FRAMES-1, move to IDLE with `cnt`<=0.
- `saved` is ignored in all non-IDLE states.
- `Player_dead` is ignored outside IDLE.
  - If it is still high on return to IDLE, a new death sequence starts on the next edge.
- `Respawn_X/Y` change only on an accepted save or on reset. They are stable throughout DYING, LOAD and BLINK.
- Positions are stored unmodified: no clamping or offset arithmetic.

## Timing

- Reset: on any edge with `Reset_h`=1, regardless of state:
  - state=IDLE, `cnt`=0.
  - checkpoint=(INIT_X, INIT_Y), `Save_count`=0.
  - `load_pos`=`freeze`=`invincible`=`blink`=`busy`=0.
  - Reset mid-sequence aborts it with no `load_pos` issued.
- A save accepted at edge N is visible on `Respawn_X/Y` and `Save_count` after edge N: one-frame latency.
- If `Player_dead` is sampled high at edge N:
  - DYING occupies edges N..N+DEATH_FRAMES-1 (`freeze`=1 from edge N).
  - LOAD is the cycle after edge N+DEATH_FRAMES.
  - BLINK covers the BLINK_FRAMES cycles after that.
  - IDLE resumes after edge N+DEATH_FRAMES+1+BLINK_FRAMES.
- `load_pos` is high for exactly one cycle per death sequence.
- `Save_count` at 15 stays at 15, but the position is still latched.

## Test plan

- Reset, then `Player_dead`=1 for one frame, with the default parameters:
  - `Respawn_X/Y`=(32,400).
  - `freeze`=1 for 31 cycles, with `load_pos`=1 only on the 31st.
  - `invincible`=1 for 61 cycles.
  - `busy` falls after 91 cycles.
- `saved` pulse with Player=(200,150) in IDLE -> next cycle `Respawn_X/Y`=(200,150) and `Save_count`=1. A subsequent death loads (200,150).
- `saved` and `Player_dead` high in the same cycle with Player=(300,100) -> checkpoint unchanged at (32,400), `Save_count`=0, DYING entered.
- `saved` pulse during DYING with Player=(10,10) -> checkpoint and count are unchanged.
- With BLINK_PERIOD=4, check the BLINK phase -> `blink` pattern is 0000 1111 0000 … over 60 frames, and `blink`=0 after returning to IDLE.
- Assert `Reset_h` for one cycle mid-DYING after 16 saves -> state IDLE, `Save_count`=0, checkpoint (32,400), and no `load_pos` pulse.
  - Before the reset, the 16 saves must show `Save_count` held at 15.
